// File: rtl/urate_sched_if.sv
// Bundle of request, engine and frame-timing signals between urate_sched and its users.
// The slave modport is the scheduler side and the master modport is the requester/engine side.
interface urate_sched_if #(
  parameter int CH    = 4,
  parameter int RATIO = 20
);
  localparam int SEL_W = $clog2(CH);
  localparam int PH_W  = $clog2(RATIO);

  logic [CH-1:0]    req;
  logic             clr;
  logic             eng_done;
  logic             eng_start;
  logic [SEL_W-1:0] eng_sel;
  logic [CH-1:0]    gnt;
  logic [PH_W-1:0]  phase;
  logic             stb_l;
  logic             busy;
  logic [CH-1:0]    ovr;
  logic             tmo_err;

  modport master (
    output req, clr, eng_done,
    input  eng_start, eng_sel, gnt, phase, stb_l, busy, ovr, tmo_err
  );

  modport slave (
    input  req, clr, eng_done,
    output eng_start, eng_sel, gnt, phase, stb_l, busy, ovr, tmo_err
  );
endinterface

// File: rtl/urate_sched.sv
// Shares one rate-conversion engine among CH low-rate requesters: frame timing,
// round-robin job issue with start/done handshake, per-frame overrun and engine timeout.
module urate_sched #(
  parameter int F_H = 60,
  parameter int F_L = 3,
  parameter int CH  = 4,
  parameter int TMO = 16
) (
  input  logic         clk,
  input  logic         rst,
  urate_sched_if.slave bus
);
  localparam int RATIO = F_H / F_L;
  localparam int SEL_W = $clog2(CH);
  localparam int PH_W  = $clog2(RATIO);
  localparam int CNT_W = $clog2(TMO + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             stb_q, stb_d;
  logic             start_q, start_d;
  logic [CH-1:0]    gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [CH-1:0]    served_q, served_d;
  logic [CH-1:0]    ovr_q, ovr_d;
  logic             tmo_q, tmo_d;
  logic             tmo_set;
  logic [SEL_W-1:0] sel_inc;

  // Lowest offset from ptr wins, so scanning offsets downward leaves the first hit.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [CH-1:0] r, input logic [SEL_W-1:0] p);
    logic [SEL_W-1:0] idx;
    rr_pick = p;
    for (int k = CH - 1; k >= 0; k--) begin
      idx = SEL_W'((int'(p) + k) % CH);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign sel_inc = (sel_q == SEL_W'(CH - 1)) ? '0 : sel_q + 1'b1;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    gnt_d    = '0;
    tmo_set  = 1'b0;

    phase_d = (phase_q == PH_W'(RATIO - 1)) ? '0 : phase_q + 1'b1;
    stb_d   = (phase_d == PH_W'(RATIO - 1));

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (|bus.req) begin
          sel_d   = rr_pick(bus.req, ptr_q);
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.eng_done) begin
          gnt_d   = CH'(1) << sel_q;
          ptr_d   = sel_inc;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(TMO - 1)) begin
          tmo_set = 1'b1;
          ptr_d   = sel_inc;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);

    // served_q already holds a grant showing in the strobe cycle; a done seen
    // in the strobe cycle grants in the next frame and seeds the fresh set.
    served_d = served_q | gnt_d;
    ovr_d    = bus.clr ? '0 : ovr_q;
    tmo_d    = bus.clr ? 1'b0 : tmo_q;
    if (stb_q) begin
      ovr_d    = ovr_d | (bus.req & ~served_q);
      served_d = gnt_d;
    end
    if (tmo_set) tmo_d = 1'b1;
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      phase_q  <= '0;
      stb_q    <= 1'b0;
      start_q  <= 1'b0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      served_q <= '0;
      ovr_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      stb_q    <= stb_d;
      start_q  <= start_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      served_q <= served_d;
      ovr_q    <= ovr_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.eng_start = start_q;
  assign bus.eng_sel   = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.phase     = phase_q;
  assign bus.stb_l     = stb_q;
  assign bus.busy      = busy_q;
  assign bus.ovr       = ovr_q;
  assign bus.tmo_err   = tmo_q;
endmodule

// File: tb/tb_urate_sched.sv
// Directed bench for urate_sched: frame timing, round-robin issue, timeout,
// overrun with clr, and reset in the middle of a job.
module tb_urate_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic eng_auto = 1'b0;
  logic eng_force = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   k = 0;
  int   done_dly = 0;
  int   eng_cnt = 0;

  urate_sched_if #(.CH(4), .RATIO(20)) bus_if ();

  urate_sched #(.F_H(60), .F_L(3), .CH(4), .TMO(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  assign bus_if.eng_done = eng_auto | eng_force;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  // Cycle k is the one whose falling edge the bench is sitting on; k = 0 right after release.
  task automatic tick_to(input int t);
    while (k < t) begin
      @(negedge clk);
      k++;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus_if.eng_start, bus_if.eng_sel, bus_if.gnt, bus_if.phase,
                bus_if.stb_l, bus_if.busy, bus_if.ovr, bus_if.tmo_err});
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    bus_if.req = '0;
    bus_if.clr = 1'b0;
    eng_force = 1'b0;
    done_dly = 0;
    repeat (10) @(negedge clk);
    check("reset_state", all_outs(), 32'd0);
    rst = 1'b1;
    k = 0;
  endtask

  // Engine: raises done for one cycle done_dly cycles after it sees eng_start.
  initial begin : engine_model
    forever begin
      @(negedge clk);
      eng_auto = 1'b0;
      if (!rst) begin
        eng_cnt = 0;
      end else begin
        if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) eng_auto = 1'b1;
        end
        if (bus_if.eng_start && done_dly > 0) eng_cnt = done_dly;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    // NOTE: inputs change with blocking assignments on the falling edge, away from the sampling edge.
    bus_if.req = '0;
    bus_if.clr = 1'b0;

    // 1: idle frame timing
    do_reset();
    for (int c = 0; c < 60; c++) begin
      tick_to(c);
      check("t1_phase", 32'(bus_if.phase), 32'(c % 20));
      check("t1_stb_l", 32'(bus_if.stb_l), 32'(c % 20 == 19));
      check("t1_quiet", 32'({bus_if.eng_start, bus_if.gnt, bus_if.ovr, bus_if.tmo_err, bus_if.busy}), 32'd0);
    end

    // 2: single job on channel 2, done 3 cycles after start
    do_reset();
    done_dly = 3;
    bus_if.req = 4'b0100;
    tick_to(1);
    check("t2_start", 32'(bus_if.eng_start), 32'd1);
    check("t2_sel", 32'(bus_if.eng_sel), 32'd2);
    check("t2_busy_issue", 32'(bus_if.busy), 32'd1);
    tick_to(2);
    check("t2_start_once", 32'(bus_if.eng_start), 32'd0);
    check("t2_busy_wait", 32'(bus_if.busy), 32'd1);
    tick_to(4);
    check("t2_gnt_early", 32'(bus_if.gnt), 32'd0);
    tick_to(5);
    check("t2_gnt", 32'(bus_if.gnt), 32'b0100);
    check("t2_busy_done", 32'(bus_if.busy), 32'd0);
    bus_if.req = '0;
    tick_to(6);
    check("t2_gnt_pulse", 32'(bus_if.gnt), 32'd0);
    check("t2_no_restart", 32'(bus_if.eng_start), 32'd0);

    // 3: all channels, round robin, done 2 cycles after start
    do_reset();
    done_dly = 2;
    bus_if.req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      tick_to(3 + 4 * g);
      check("t3_gnt_gap", 32'(bus_if.gnt), 32'd0);
      tick_to(4 + 4 * g);
      check("t3_gnt", 32'(bus_if.gnt), 32'(1) << (g % 4));
      check("t3_ovr", 32'(bus_if.ovr), 32'd0);
      bus_if.req[g % 4] = 1'b0;
      tick_to(5 + 4 * g);
      bus_if.req[g % 4] = 1'b1;
    end
    bus_if.req = '0;
    tick_to(22);
    check("t3_ovr_end", 32'(bus_if.ovr), 32'd0);

    // 4: engine never answers
    do_reset();
    bus_if.req = 4'b0001;
    tick_to(1);
    check("t4_start", 32'(bus_if.eng_start), 32'd1);
    check("t4_sel", 32'(bus_if.eng_sel), 32'd0);
    tick_to(2);
    bus_if.req = 4'b0011;
    for (int c = 2; c < 18; c++) begin
      tick_to(c);
      check("t4_wait", 32'({bus_if.busy, bus_if.tmo_err, bus_if.gnt}), 32'b1_0_0000);
    end
    tick_to(18);
    check("t4_tmo_err", 32'(bus_if.tmo_err), 32'd1);
    check("t4_busy_fall", 32'(bus_if.busy), 32'd0);
    check("t4_no_gnt", 32'(bus_if.gnt), 32'd0);
    tick_to(19);
    check("t4_next_start", 32'(bus_if.eng_start), 32'd1);
    check("t4_next_sel", 32'(bus_if.eng_sel), 32'd1);
    tick_to(20);
    check("t4_ovr_inflight", 32'(bus_if.ovr), 32'b0011);
    check("t4_tmo_sticky", 32'(bus_if.tmo_err), 32'd1);
    tick_to(22);
    bus_if.clr = 1'b1;
    tick_to(23);
    bus_if.clr = 1'b0;
    check("t4_clr_tmo", 32'(bus_if.tmo_err), 32'd0);
    check("t4_clr_ovr", 32'(bus_if.ovr), 32'd0);

    // 5: overrun with slow engine, done 8 cycles after start
    do_reset();
    done_dly = 8;
    bus_if.req = 4'hF;
    tick_to(10);
    check("t5_gnt0", 32'(bus_if.gnt), 32'b0001);
    tick_to(19);
    check("t5_stb1", 32'(bus_if.stb_l), 32'd1);
    check("t5_ovr_pre", 32'(bus_if.ovr), 32'd0);
    tick_to(20);
    check("t5_gnt1", 32'(bus_if.gnt), 32'b0010);
    check("t5_ovr_frame1", 32'(bus_if.ovr), 32'b1110);
    tick_to(21);
    bus_if.clr = 1'b1;
    tick_to(22);
    bus_if.clr = 1'b0;
    check("t5_ovr_clr", 32'(bus_if.ovr), 32'd0);
    tick_to(30);
    check("t5_gnt2", 32'(bus_if.gnt), 32'b0100);
    tick_to(39);
    check("t5_stb2", 32'(bus_if.stb_l), 32'd1);
    bus_if.clr = 1'b1;
    tick_to(40);
    bus_if.clr = 1'b0;
    check("t5_ovr_set_wins", 32'(bus_if.ovr), 32'b1001);
    check("t5_gnt3", 32'(bus_if.gnt), 32'b1000);

    // 6: reset on the third WAIT cycle
    do_reset();
    bus_if.req = 4'b0100;
    tick_to(1);
    check("t6_start", 32'(bus_if.eng_start), 32'd1);
    check("t6_sel", 32'(bus_if.eng_sel), 32'd2);
    tick_to(4);
    check("t6_busy_wait3", 32'(bus_if.busy), 32'd1);
    rst = 1'b0;
    bus_if.req = '0;
    tick_to(5);
    check("t6_reset_outs", all_outs(), 32'd0);
    rst = 1'b1;
    k = 0;
    tick_to(2);
    eng_force = 1'b1;
    tick_to(3);
    eng_force = 1'b0;
    check("t6_stale_done_gnt", 32'(bus_if.gnt), 32'd0);
    check("t6_idle", 32'(bus_if.busy), 32'd0);
    bus_if.req = 4'b0101;
    tick_to(4);
    check("t6_gnt_quiet", 32'(bus_if.gnt), 32'd0);
    check("t6_restart", 32'(bus_if.eng_start), 32'd1);
    check("t6_ptr_zero", 32'(bus_if.eng_sel), 32'd0);
    check("t6_phase", 32'(bus_if.phase), 32'd4);
    bus_if.req = '0;
    tick_to(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
